// File: rtl/digital_clock_alarm.sv
// BCD time-of-day clock with a prescaled one-second tick, 12/24h display,
// validated time load and a single daily alarm that times out after RING_SECS.
module digital_clock_alarm #(
    parameter int CLK_FREQ  = 1_200_000,
    parameter int RING_SECS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_12h,
    input  logic       load_en,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic       one_sec_pulse,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic       pm,
    output logic       alarm_ring,
    output logic       load_err
);

    localparam int             PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 2;
    localparam logic [PW-1:0]  TC = PW'(CLK_FREQ - 1);
    localparam logic [7:0]     RING_LAST = 8'(RING_SECS - 1);

    typedef struct packed {
        logic [3:0] hh_t;
        logic [3:0] hh_o;
        logic [3:0] mm_t;
        logic [3:0] mm_o;
        logic [3:0] ss_t;
        logic [3:0] ss_o;
    } tod_t;

    tod_t          tod_q, tod_inc, tod_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    alarm_hh_q, alarm_mm_q;
    logic [7:0]    ring_cnt_q;
    logic [3:0]    hour_tens_d, hour_ones_d;
    logic          pm_d;
    logic          tick, load_ok, alarm_ok, do_load, do_tick, trigger;
    logic [4:0]    hour_bin, hour_disp;

    function automatic logic hh_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd1 && v[3:0] <= 4'd9) || (v[7:4] == 4'd2 && v[3:0] <= 4'd3);
    endfunction

    function automatic logic ms_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    assign tick     = (presc_q == TC);
    assign load_ok  = hh_ok(load_hh) && ms_ok(load_mm) && ms_ok(load_ss);
    assign alarm_ok = hh_ok(alarm_hh) && ms_ok(alarm_mm);
    assign do_load  = load_en && load_ok;
    // A valid load restarts the second, so a coincident tick is dropped.
    assign do_tick  = tick && !do_load;

    // Cascaded BCD increment; every digit wraps at its own limit.
    always_comb begin
        // NOTE: default first so every path assigns every field -- no latch.
        tod_inc = tod_q;
        if (tod_q.ss_o != 4'd9) begin
            tod_inc.ss_o = tod_q.ss_o + 4'd1;
        end else begin
            tod_inc.ss_o = 4'd0;
            if (tod_q.ss_t != 4'd5) begin
                tod_inc.ss_t = tod_q.ss_t + 4'd1;
            end else begin
                tod_inc.ss_t = 4'd0;
                if (tod_q.mm_o != 4'd9) begin
                    tod_inc.mm_o = tod_q.mm_o + 4'd1;
                end else begin
                    tod_inc.mm_o = 4'd0;
                    if (tod_q.mm_t != 4'd5) begin
                        tod_inc.mm_t = tod_q.mm_t + 4'd1;
                    end else begin
                        tod_inc.mm_t = 4'd0;
                        if (tod_q.hh_t == 4'd2 && tod_q.hh_o == 4'd3) begin
                            tod_inc.hh_t = 4'd0;
                            tod_inc.hh_o = 4'd0;
                        end else if (tod_q.hh_o == 4'd9) begin
                            tod_inc.hh_o = 4'd0;
                            tod_inc.hh_t = tod_q.hh_t + 4'd1;
                        end else begin
                            tod_inc.hh_o = tod_q.hh_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        tod_d   = tod_q;
        presc_d = presc_q + PW'(1);
        if (do_load) begin
            tod_d   = '{hh_t: load_hh[7:4], hh_o: load_hh[3:0],
                        mm_t: load_mm[7:4], mm_o: load_mm[3:0],
                        ss_t: load_ss[7:4], ss_o: load_ss[3:0]};
            presc_d = '0;
        end else if (tick) begin
            tod_d   = tod_inc;
            presc_d = '0;
        end
    end

    assign trigger = do_tick && alarm_en
                   && tod_inc.ss_t == 4'd0 && tod_inc.ss_o == 4'd0
                   && {tod_inc.hh_t, tod_inc.hh_o} == alarm_hh_q
                   && {tod_inc.mm_t, tod_inc.mm_o} == alarm_mm_q;

    // Hour display is derived from the next time so it changes with the pulse.
    always_comb begin
        hour_bin    = 5'(tod_d.hh_t) * 5'd10 + 5'(tod_d.hh_o);
        pm_d        = (hour_bin >= 5'd12);
        hour_disp   = hour_bin;
        hour_tens_d = 4'd0;
        hour_ones_d = 4'd0;
        if (mode_12h) begin
            if (hour_bin == 5'd0)
                hour_disp = 5'd12;
            else if (hour_bin > 5'd12)
                hour_disp = hour_bin - 5'd12;
        end
        if (hour_disp >= 5'd20) begin
            hour_tens_d = 4'd2;
            hour_ones_d = 4'(hour_disp - 5'd20);
        end else if (hour_disp >= 5'd10) begin
            hour_tens_d = 4'd1;
            hour_ones_d = 4'(hour_disp - 5'd10);
        end else begin
            hour_ones_d = 4'(hour_disp);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tod_q         <= '0;
            presc_q       <= '0;
            one_sec_pulse <= 1'b0;
            hour_tens     <= 4'd0;
            hour_ones     <= 4'd0;
            pm            <= 1'b0;
            load_err      <= 1'b0;
            alarm_hh_q    <= 8'h00;
            alarm_mm_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            tod_q         <= tod_d;
            presc_q       <= presc_d;
            one_sec_pulse <= do_tick;
            hour_tens     <= hour_tens_d;
            hour_ones     <= hour_ones_d;
            pm            <= pm_d;
            load_err      <= (load_en && !load_ok) || (alarm_set && !alarm_ok);
            if (alarm_set && alarm_ok) begin
                alarm_hh_q <= alarm_hh;
                alarm_mm_q <= alarm_mm;
            end
        end
    end

    // A fresh trigger outranks ack/disable; otherwise the ring counts down pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_ring <= 1'b0;
            ring_cnt_q <= 8'd0;
        end else if (trigger) begin
            alarm_ring <= 1'b1;
            ring_cnt_q <= 8'd0;
        end else if (alarm_ring) begin
            if (alarm_ack || !alarm_en) begin
                alarm_ring <= 1'b0;
            end else if (do_tick) begin
                if (ring_cnt_q == RING_LAST)
                    alarm_ring <= 1'b0;
                else
                    ring_cnt_q <= ring_cnt_q + 8'd1;
            end
        end
    end

    assign sec_ones = tod_q.ss_o;
    assign sec_tens = tod_q.ss_t;
    assign min_ones = tod_q.mm_o;
    assign min_tens = tod_q.mm_t;

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Directed bench for digital_clock_alarm with CLK_FREQ=10, RING_SECS=3.
module tb_digital_clock_alarm;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_12h, load_en, alarm_set, alarm_en, alarm_ack;
    logic [7:0] load_hh, load_mm, load_ss, alarm_hh, alarm_mm;
    logic       one_sec_pulse, pm, alarm_ring, load_err;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;

    int total = 0;
    int bad   = 0;

    digital_clock_alarm #(.CLK_FREQ(10), .RING_SECS(3)) dut (
        .clk(clk), .reset(reset), .mode_12h(mode_12h),
        .load_en(load_en), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .alarm_set(alarm_set), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .one_sec_pulse(one_sec_pulse),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens),
        .pm(pm), .alarm_ring(alarm_ring), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] disp();
        return {8'h00, hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        load_hh = hh; load_mm = mm; load_ss = ss; load_en = 1'b1;
        step(1);
        load_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; mode_12h = 1'b0; load_en = 1'b0; alarm_set = 1'b0;
        alarm_en = 1'b0; alarm_ack = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        alarm_hh = 8'h00; alarm_mm = 8'h00;
        step(2);
        check("rst_time", disp(), 32'h000000);
        check("rst_pulse", 32'(one_sec_pulse), 0);
        check("rst_ring", 32'(alarm_ring), 0);
        check("rst_err", 32'(load_err), 0);

        // First pulse lands on the 10th edge after release.
        reset = 1'b1;
        step(9);
        check("pre_pulse", 32'(one_sec_pulse), 0);
        step(1);
        check("first_pulse", 32'(one_sec_pulse), 1);
        check("first_time", disp(), 32'h000001);
        step(1);
        check("pulse_width", 32'(one_sec_pulse), 0);
        step(9);
        check("second_pulse", 32'(one_sec_pulse), 1);
        check("second_time", disp(), 32'h000002);

        // Day rollover, 24h then 12h display.
        load(8'h23, 8'h59, 8'h58);
        check("load_time", disp(), 32'h235958);
        check("load_nopulse", 32'(one_sec_pulse), 0);
        step(10);
        check("roll1_pulse", 32'(one_sec_pulse), 1);
        check("roll1_time", disp(), 32'h235959);
        mode_12h = 1'b1;
        step(1);
        check("h12_2359", disp(), 32'h115959);
        check("h12_pm1", 32'(pm), 1);
        step(9);
        check("roll2_pulse", 32'(one_sec_pulse), 1);
        check("h12_midnight", disp(), 32'h120000);
        check("h12_pm0", 32'(pm), 0);
        mode_12h = 1'b0;
        step(1);
        check("h24_midnight", disp(), 32'h000000);
        mode_12h = 1'b1;
        load(8'h15, 8'h00, 8'h00);
        check("h12_15", disp(), 32'h030000);
        check("h12_15_pm", 32'(pm), 1);
        mode_12h = 1'b0;
        step(1);
        check("h24_15", disp(), 32'h150000);

        // Rejected loads leave time untouched.
        load(8'h24, 8'h00, 8'h00);
        check("bad_hh_err", 32'(load_err), 1);
        check("bad_hh_time", disp(), 32'h150000);
        step(1);
        check("err_1cycle", 32'(load_err), 0);
        load(8'h12, 8'h00, 8'h5A);
        check("bad_ss_err", 32'(load_err), 1);
        check("bad_ss_time", disp(), 32'h150000);
        step(1);

        // Load on the tick cycle discards the tick.
        load(8'h12, 8'h34, 8'h56);
        step(9);
        check("pre_tick", 32'(one_sec_pulse), 0);
        load(8'h01, 8'h02, 8'h03);
        check("tick_load_time", disp(), 32'h010203);
        check("tick_load_nopulse", 32'(one_sec_pulse), 0);
        step(9);
        check("tick_load_wait", 32'(one_sec_pulse), 0);
        step(1);
        check("tick_load_next", 32'(one_sec_pulse), 1);
        check("tick_load_next_t", disp(), 32'h010204);

        // Alarm 07:30 with auto-timeout after 3 further pulses.
        alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_set = 1'b1; alarm_en = 1'b1;
        load(8'h07, 8'h29, 8'h59);
        alarm_set = 1'b0;
        check("alarm_load_err", 32'(load_err), 0);
        check("alarm_noring", 32'(alarm_ring), 0);
        step(10);
        check("alarm_trig_time", disp(), 32'h073000);
        check("alarm_trig", 32'(alarm_ring), 1);
        step(20);
        check("ring_after2", 32'(alarm_ring), 1);
        step(10);
        check("ring_timeout_p", 32'(one_sec_pulse), 1);
        check("ring_timeout", 32'(alarm_ring), 0);

        // Acknowledge.
        load(8'h07, 8'h29, 8'h59);
        step(10);
        check("ack_trig", 32'(alarm_ring), 1);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        check("ack_off", 32'(alarm_ring), 0);
        step(10);
        check("ack_stays_off", 32'(alarm_ring), 0);

        // Disabled alarm, and a direct load onto the alarm time.
        alarm_en = 1'b0;
        load(8'h07, 8'h29, 8'h59);
        step(10);
        check("dis_time", disp(), 32'h073000);
        check("dis_noring", 32'(alarm_ring), 0);
        alarm_en = 1'b1;
        load(8'h07, 8'h30, 8'h00);
        check("direct_noring", 32'(alarm_ring), 0);
        step(10);
        check("direct_next", disp(), 32'h073001);
        check("direct_noring2", 32'(alarm_ring), 0);

        // Rejected alarm_set keeps the 07:30 alarm.
        alarm_hh = 8'h24; alarm_mm = 8'h30; alarm_set = 1'b1;
        step(1);
        alarm_set = 1'b0;
        check("bad_alarm_err", 32'(load_err), 1);
        load(8'h07, 8'h29, 8'h59);
        step(10);
        check("kept_alarm", 32'(alarm_ring), 1);

        // Asynchronous reset mid-ring and mid-count.
        step(4);
        #2 reset = 1'b0;
        #1;
        check("async_time", disp(), 32'h000000);
        check("async_ring", 32'(alarm_ring), 0);
        check("async_pulse", 32'(one_sec_pulse), 0);
        check("async_pm", 32'(pm), 0);
        step(1);
        reset = 1'b1;
        step(10);
        check("rst2_pulse", 32'(one_sec_pulse), 1);
        check("rst2_time", disp(), 32'h000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
